// File: rtl/led_activity_pkg.sv
// led_activity_pkg: shared types and constants for the LED activity front end.
//   - Trigger bit indices. The top level uses these names to wire
//     led_activity to the blinker.
//   - FSM state enums for the link debouncer and the rx frame tracker.
//   - Helpers that size counters from their maximum values.
package led_activity_pkg;

  localparam int LED_RX   = 0;  // good rx frame
  localparam int LED_TX   = 1;  // tx frame start
  localparam int LED_ERR  = 2;  // rx error or runt
  localparam int LED_LINK = 3;  // debounced link change
  localparam int NUM_TRIG = 4;

  typedef enum logic [1:0] {
    LINK_DOWN,
    LINK_UP_PEND,
    LINK_UP,
    LINK_DOWN_PEND
  } link_state_e;

  typedef enum logic {
    RX_IDLE,
    RX_FRAME
  } rx_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold values 0..max_val. The result is at least 1 bit.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/led_activity_if.sv
// led_activity_if: status inputs and trigger outputs of led_activity.
//   master: the side that drives the status and reads the triggers (MAC/PCS side).
//   slave : the led_activity block.
//   Signals:
//     test_mode, link_status, rx_valid, rx_err, tx_valid -> slave
//     triggers[NUM_TRIG-1:0], link_led                   -> master
interface led_activity_if;
  import led_activity_pkg::*;

  logic                test_mode;
  logic                link_status;
  logic                rx_valid;
  logic                rx_err;
  logic                tx_valid;
  logic [NUM_TRIG-1:0] triggers;
  logic                link_led;

  modport master (
    output test_mode, link_status, rx_valid, rx_err, tx_valid,
    input  triggers, link_led
  );

  modport slave (
    input  test_mode, link_status, rx_valid, rx_err, tx_valid,
    output triggers, link_led
  );
endinterface

// File: rtl/led_activity_link_debounce.sv
// link_debounce: debounces the raw link indication using a four-state FSM.
//   clk, rst_n : clock and synchronous active-low reset
//   threshold  : number of steady cycles needed to accept a change. This input
//                is sampled every cycle.
//   in         : raw link status
//   out        : debounced link state (registered)
//   changed    : one-cycle pulse, registered together with each change of out
module link_debounce
  import led_activity_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] threshold,
  input  logic             in,
  output logic             out,
  output logic             changed
);

  link_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             changed_q, changed_d;

  // Compute count+1 with one extra bit, so the threshold compare is exact and
  // the counter can saturate instead of wrapping.
  logic [CNT_W:0]   cnt_p1;
  logic [CNT_W-1:0] cnt_inc;
  logic             reached;

  always_comb begin
    cnt_p1  = {1'b0, cnt_q} + (CNT_W+1)'(1);
    cnt_inc = cnt_p1[CNT_W] ? cnt_q : cnt_p1[CNT_W-1:0];
    reached = (cnt_p1 >= {1'b0, threshold});
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    changed_d = 1'b0;
    unique case (state_q)
      LINK_DOWN: begin
        cnt_d = '0;
        if (in) state_d = LINK_UP_PEND;
      end
      LINK_UP: begin
        cnt_d = '0;
        if (!in) state_d = LINK_DOWN_PEND;
      end
      LINK_UP_PEND: begin
        if (!in) begin
          state_d = LINK_DOWN;
          cnt_d   = '0;
        end else if (reached) begin
          state_d   = LINK_UP;
          cnt_d     = '0;
          out_d     = 1'b1;
          changed_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      LINK_DOWN_PEND: begin
        if (in) begin
          state_d = LINK_UP;
          cnt_d   = '0;
        end else if (reached) begin
          state_d   = LINK_DOWN;
          cnt_d     = '0;
          out_d     = 1'b0;
          changed_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = LINK_DOWN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= LINK_DOWN;
      cnt_q     <= '0;
      out_q     <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      changed_q <= changed_d;
    end
  end

  assign out     = out_q;
  assign changed = changed_q;

endmodule

// File: rtl/led_activity.sv
// led_activity: turns raw MAC/PCS status into one-cycle LED trigger pulses and
// a debounced link indication.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : led_activity_if.slave
//     in : test_mode, link_status, rx_valid, rx_err, tx_valid
//     out: triggers[LED_RX/LED_TX/LED_ERR/LED_LINK] (registered pulses),
//          link_led (registered)
// When link_led is low, the rx and tx pulses are suppressed and the rx tracker
// is held idle. The link-change pulse is never suppressed.
module led_activity
  import led_activity_pkg::*;
#(
  parameter int unsigned RUNT_CYCLES        = 64,
  parameter int unsigned LINK_DEBOUNCE      = 1250000,
  parameter int unsigned TEST_LINK_DEBOUNCE = 16
) (
  input logic           clk,
  input logic           rst_n,
  led_activity_if.slave bus
);

  localparam int unsigned CNT_W = cnt_w(max_u(LINK_DEBOUNCE, TEST_LINK_DEBOUNCE));
  localparam int unsigned LEN_W = cnt_w(RUNT_CYCLES);
  localparam logic [CNT_W-1:0] THR_NORM = CNT_W'(LINK_DEBOUNCE);
  localparam logic [CNT_W-1:0] THR_TEST = CNT_W'(TEST_LINK_DEBOUNCE);
  localparam logic [LEN_W-1:0] RUNT_L   = LEN_W'(RUNT_CYCLES);

  logic [CNT_W-1:0] threshold;
  logic             deb_out, deb_changed;

  rx_state_e           rx_state_q, rx_state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                err_q, err_d;
  logic                tx_prev_q, tx_prev_d;
  logic [NUM_TRIG-1:0] trig_q, trig_d;
  logic                link_led_q, link_led_d;

  assign threshold = bus.test_mode ? THR_TEST : THR_NORM;

  link_debounce #(.CNT_W(CNT_W)) u_link_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .threshold (threshold),
    .in        (bus.link_status),
    .out       (deb_out),
    .changed   (deb_changed)
  );

  always_comb begin
    rx_state_d = rx_state_q;
    len_d      = len_q;
    err_d      = err_q;
    trig_d     = '0;
    tx_prev_d  = bus.tx_valid;
    link_led_d = deb_out;

    trig_d[LED_TX] = bus.tx_valid & ~tx_prev_q;

    unique case (rx_state_q)
      RX_IDLE: begin
        if (bus.rx_valid) begin
          rx_state_d = RX_FRAME;
          len_d      = LEN_W'(1);
          err_d      = bus.rx_err;
        end
      end
      RX_FRAME: begin
        if (bus.rx_valid) begin
          if (len_q < RUNT_L) len_d = len_q + LEN_W'(1);
          err_d = err_q | bus.rx_err;
        end else begin
          rx_state_d = RX_IDLE;
          len_d      = '0;
          err_d      = 1'b0;
          if (err_q || (len_q < RUNT_L)) trig_d[LED_ERR] = 1'b1;
          else                           trig_d[LED_RX]  = 1'b1;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
        len_d      = '0;
        err_d      = 1'b0;
      end
    endcase

    // With the link down, traffic is not shown, and any open frame is
    // dropped without a pulse.
    if (!link_led_q) begin
      trig_d[LED_RX]  = 1'b0;
      trig_d[LED_TX]  = 1'b0;
      trig_d[LED_ERR] = 1'b0;
      rx_state_d      = RX_IDLE;
      len_d           = '0;
      err_d           = 1'b0;
    end

    trig_d[LED_LINK] = deb_changed;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      len_q      <= '0;
      err_q      <= 1'b0;
      tx_prev_q  <= 1'b0;
      trig_q     <= '0;
      link_led_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      len_q      <= len_d;
      err_q      <= err_d;
      tx_prev_q  <= tx_prev_d;
      trig_q     <= trig_d;
      link_led_q <= link_led_d;
    end
  end

  assign bus.triggers = trig_q;
  assign bus.link_led = link_led_q;

endmodule

// File: tb/tb_led_activity.sv
module tb_led_activity;
  import led_activity_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  led_activity_if bus ();

  led_activity #(
    .RUNT_CYCLES        (64),
    .LINK_DEBOUNCE      (1250000),
    .TEST_LINK_DEBOUNCE (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] et, input logic el);
    n_cmp++;
    assert (bus.triggers === et) else begin
      n_bad++;
      $error("FAIL %s triggers observed %b expected %b", tag, bus.triggers, et);
    end
    n_cmp++;
    assert (bus.link_led === el) else begin
      n_bad++;
      $error("FAIL %s link_led observed %b expected %b", tag, bus.link_led, el);
    end
  endtask

  task automatic run(input string tag, input int n, input logic [3:0] et, input logic el);
    repeat (n) begin
      step();
      chk(tag, et, el);
    end
  endtask

  // A raw change held steady: 17 quiet cycles, then led and the link pulse together.
  task automatic link_change(input string tag, input logic v);
    bus.link_status = v;
    run({tag, "_wait"}, 17, 4'b0000, ~v);
    step(); chk({tag, "_edge"}, 4'b1000, v);
    step(); chk({tag, "_after"}, 4'b0000, v);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.test_mode   = 1'b1;
    bus.link_status = 1'b0;
    bus.rx_valid    = 1'b0;
    bus.rx_err      = 1'b0;
    bus.tx_valid    = 1'b0;
    repeat (3) step();
    chk("reset", 4'b0000, 1'b0);
    rst_n = 1'b1;

    // Link glitch shorter than the threshold
    bus.link_status = 1'b1;
    run("glitch_hi", 10, 4'b0000, 1'b0);
    bus.link_status = 1'b0;
    run("glitch_lo", 30, 4'b0000, 1'b0);

    // Link up
    link_change("link_up", 1'b1);

    // rx_err without rx_valid has no effect
    bus.rx_err = 1'b1;
    run("err_idle", 3, 4'b0000, 1'b1);
    bus.rx_err = 1'b0;

    // Good frame of exactly RUNT_CYCLES
    bus.rx_valid = 1'b1;
    run("good_body", 64, 4'b0000, 1'b1);
    bus.rx_valid = 1'b0;
    step(); chk("good_end", 4'b0001, 1'b1);
    step(); chk("good_after", 4'b0000, 1'b1);

    // Runt frame
    bus.rx_valid = 1'b1;
    run("runt_body", 63, 4'b0000, 1'b1);
    bus.rx_valid = 1'b0;
    step(); chk("runt_end", 4'b0100, 1'b1);
    step(); chk("runt_after", 4'b0000, 1'b1);

    // Long frame containing a single error cycle
    bus.rx_valid = 1'b1;
    run("errf_body1", 49, 4'b0000, 1'b1);
    bus.rx_err = 1'b1;
    run("errf_err", 1, 4'b0000, 1'b1);
    bus.rx_err = 1'b0;
    run("errf_body2", 50, 4'b0000, 1'b1);
    bus.rx_valid = 1'b0;
    step(); chk("errf_end", 4'b0100, 1'b1);
    step(); chk("errf_after", 4'b0000, 1'b1);

    // Back-to-back frames (1,0,1): the second frame's length restarts at 1
    bus.rx_valid = 1'b1;
    run("b2b_a", 64, 4'b0000, 1'b1);
    bus.rx_valid = 1'b0;
    step(); chk("b2b_a_end", 4'b0001, 1'b1);
    bus.rx_valid = 1'b1;
    run("b2b_b", 64, 4'b0000, 1'b1);
    bus.rx_valid = 1'b0;
    step(); chk("b2b_b_end", 4'b0001, 1'b1);
    step(); chk("b2b_after", 4'b0000, 1'b1);

    // Tx rising edge
    bus.tx_valid = 1'b1;
    step(); chk("tx_rise", 4'b0010, 1'b1);
    step(); chk("tx_hold", 4'b0000, 1'b1);
    bus.tx_valid = 1'b0;
    step(); chk("tx_fall", 4'b0000, 1'b1);

    // Rx end coincides with a tx rise
    bus.rx_valid = 1'b1;
    run("sim_body", 64, 4'b0000, 1'b1);
    bus.rx_valid = 1'b0;
    bus.tx_valid = 1'b1;
    step(); chk("sim_end", 4'b0011, 1'b1);
    bus.tx_valid = 1'b0;
    step(); chk("sim_after", 4'b0000, 1'b1);

    // Link drops mid-frame: frame discarded, tx suppressed
    bus.rx_valid = 1'b1;
    run("gate_body", 5, 4'b0000, 1'b1);
    link_change("link_down", 1'b0);
    bus.rx_valid = 1'b0;
    step(); chk("gate_rx_end", 4'b0000, 1'b0);
    bus.tx_valid = 1'b1;
    step(); chk("gate_tx", 4'b0000, 1'b0);
    bus.tx_valid = 1'b0;
    step(); chk("gate_tx_off", 4'b0000, 1'b0);

    // Reset in the middle of a frame and a pending debounce
    link_change("relink", 1'b1);
    bus.rx_valid = 1'b1;
    run("rst_frame", 10, 4'b0000, 1'b1);
    bus.link_status = 1'b0;
    run("rst_pend", 5, 4'b0000, 1'b1);
    rst_n = 1'b0;
    step(); chk("rst_mid", 4'b0000, 1'b0);
    rst_n = 1'b1;
    bus.rx_valid = 1'b0;
    run("rst_quiet", 20, 4'b0000, 1'b0);
    link_change("post_rst_up", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
